// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the two execute-stage requesters
// (0 = EXU integer path, 1 = AGU/LSU path) and the shared-ALU arbiter.
interface alu_share_arb_if #(
   parameter int BITS = 32
);
   logic            r0_valid;
   logic            r0_ready;
   logic [3:0]      r0_ctr;
   logic [BITS-1:0] r0_a;
   logic [BITS-1:0] r0_b;

   logic            r1_valid;
   logic            r1_ready;
   logic [3:0]      r1_ctr;
   logic [BITS-1:0] r1_a;
   logic [BITS-1:0] r1_b;

   logic            p0_valid;
   logic            p0_ready;
   logic [BITS-1:0] p0_data;
   logic [3:0]      p0_flags;

   logic            p1_valid;
   logic            p1_ready;
   logic [BITS-1:0] p1_data;
   logic [3:0]      p1_flags;

   modport slave (
      input  r0_valid, r0_ctr, r0_a, r0_b,
      output r0_ready,
      input  r1_valid, r1_ctr, r1_a, r1_b,
      output r1_ready,
      output p0_valid, p0_data, p0_flags,
      input  p0_ready,
      output p1_valid, p1_data, p1_flags,
      input  p1_ready
   );

   modport master (
      output r0_valid, r0_ctr, r0_a, r0_b,
      input  r0_ready,
      output r1_valid, r1_ctr, r1_a, r1_b,
      input  r1_ready,
      input  p0_valid, p0_data, p0_flags,
      output p0_ready,
      input  p1_valid, p1_data, p1_flags,
      output p1_ready
   );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one combinational ALU between two requesters,
// with a registered result/flags slot per requester on a valid/ready channel.
module alu_share_arb #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst,
   alu_share_arb_if.slave  bus,
   output logic [3:0]      alu_ctr,
   output logic [BITS-1:0] alu_a,
   output logic [BITS-1:0] alu_b,
   input  logic [BITS-1:0] alu_out,
   input  logic            alu_zero,
   input  logic            alu_carry,
   input  logic            alu_less,
   input  logic            alu_overflow
);
   localparam int N = 2;

   logic            req_valid [N];
   logic [3:0]      req_ctr   [N];
   logic [BITS-1:0] req_a     [N];
   logic [BITS-1:0] req_b     [N];
   logic            rsp_ready [N];

   logic [N-1:0]    elig;
   logic [N-1:0]    grant;
   logic [3:0]      alu_flags;

   logic [N-1:0]    rsp_valid_q, rsp_valid_d;
   logic [BITS-1:0] rsp_data_q  [N];
   logic [BITS-1:0] rsp_data_d  [N];
   logic [3:0]      rsp_flags_q [N];
   logic [3:0]      rsp_flags_d [N];
   logic            last_grant_q, last_grant_d;

   assign req_valid[0] = bus.r0_valid;
   assign req_ctr[0]   = bus.r0_ctr;
   assign req_a[0]     = bus.r0_a;
   assign req_b[0]     = bus.r0_b;
   assign rsp_ready[0] = bus.p0_ready;

   assign req_valid[1] = bus.r1_valid;
   assign req_ctr[1]   = bus.r1_ctr;
   assign req_a[1]     = bus.r1_a;
   assign req_b[1]     = bus.r1_b;
   assign rsp_ready[1] = bus.p1_ready;

   assign alu_flags = {alu_overflow, alu_less, alu_carry, alu_zero};

   // A slot being drained this cycle can be refilled in the same cycle.
   for (genvar gi = 0; gi < N; gi++) begin : g_elig
      assign elig[gi] = req_valid[gi] && (!rsp_valid_q[gi] || rsp_ready[gi]);
   end

   always_comb begin
      grant = '0;
      if (!rst) begin
         unique case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // Idle ALU inputs are forced to zero so the shared unit sees no stale operands.
   always_comb begin
      alu_ctr = '0;
      alu_a   = '0;
      alu_b   = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            alu_ctr = req_ctr[i];
            alu_a   = req_a[i];
            alu_b   = req_b[i];
         end
      end
   end

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      last_grant_d = last_grant_q;
      for (int i = 0; i < N; i++) begin
         rsp_data_d[i]  = rsp_data_q[i];
         rsp_flags_d[i] = rsp_flags_q[i];
         if (grant[i]) begin
            rsp_valid_d[i] = 1'b1;
            rsp_data_d[i]  = alu_out;
            rsp_flags_d[i] = alu_flags;
            last_grant_d   = (i != 0);
         end else if (rsp_valid_q[i] && rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
         end
      end
   end

   // After reset last_grant points at requester 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q  <= '0;
         last_grant_q <= 1'b1;
         for (int i = 0; i < N; i++) begin
            rsp_data_q[i]  <= '0;
            rsp_flags_q[i] <= '0;
         end
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         last_grant_q <= last_grant_d;
         for (int i = 0; i < N; i++) begin
            rsp_data_q[i]  <= rsp_data_d[i];
            rsp_flags_q[i] <= rsp_flags_d[i];
         end
      end
   end

   assign bus.r0_ready = grant[0];
   assign bus.r1_ready = grant[1];

   assign bus.p0_valid = rsp_valid_q[0];
   assign bus.p0_data  = rsp_data_q[0];
   assign bus.p0_flags = rsp_flags_q[0];

   assign bus.p1_valid = rsp_valid_q[1];
   assign bus.p1_data  = rsp_data_q[1];
   assign bus.p1_flags = rsp_flags_q[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural shared ALU, directed scenarios, then
// randomized traffic checked against a slot/round-robin reference model.
module tb_alu_share_arb;
   localparam int BITS = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      alu_ctr;
   logic [BITS-1:0] alu_a;
   logic [BITS-1:0] alu_b;
   logic [BITS-1:0] alu_out;
   logic            alu_zero, alu_carry, alu_less, alu_overflow;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [1:0]  m_pv;
   logic [35:0] m_res [2];
   logic        m_lg;
   logic [1:0]  m_gr;
   logic [1:0]  obs_gr;

   logic [3:0]  ctr_tab [7] = '{4'b0000, 4'b1000, 4'b0010, 4'b0100, 4'b0110, 4'b0111, 4'b1111};

   alu_share_arb_if #(.BITS(BITS)) bus ();

   alu_share_arb #(.BITS(BITS)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .alu_ctr      (alu_ctr),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_out      (alu_out),
      .alu_zero     (alu_zero),
      .alu_carry    (alu_carry),
      .alu_less     (alu_less),
      .alu_overflow (alu_overflow)
   );

   always #5 clk = ~clk;

   // Returns {overflow, less, carry, zero, result}.
   function automatic logic [35:0] alu_fn(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] wide;
      logic [31:0] y;
      logic        c, v, lt;
      wide = '0;
      c    = 1'b0;
      v    = 1'b0;
      lt   = $signed(a) < $signed(b);
      case (ctr)
         4'b0000: begin
            wide = {1'b0, a} + {1'b0, b};
            y = wide[31:0]; c = wide[32];
            v = (a[31] == b[31]) && (y[31] != a[31]);
         end
         4'b1000: begin
            wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
            y = wide[31:0]; c = wide[32];
            v = (a[31] != b[31]) && (y[31] != a[31]);
         end
         4'b0010: y = {31'b0, lt};
         4'b0100: y = a ^ b;
         4'b0110: y = a | b;
         4'b0111: y = a & b;
         default: y = b;
      endcase
      return {v, lt, c, (y == 32'd0), y};
   endfunction

   always_comb begin
      {alu_overflow, alu_less, alu_carry, alu_zero, alu_out} = alu_fn(alu_ctr, alu_a, alu_b);
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   task automatic set_r0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      bus.r0_valid = v; bus.r0_ctr = c; bus.r0_a = a; bus.r0_b = b;
   endtask

   task automatic set_r1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      bus.r1_valid = v; bus.r1_ctr = c; bus.r1_a = a; bus.r1_b = b;
   endtask

   task automatic new_r0(input logic v);
      set_r0(v, ctr_tab[$urandom_range(0, 6)], rand_op(), rand_op());
   endtask

   task automatic new_r1(input logic v);
      set_r1(v, ctr_tab[$urandom_range(0, 6)], rand_op(), rand_op());
   endtask

   // One clock: check outputs against the model mid-cycle, then advance the model.
   task automatic step();
      logic [1:0]  el, gr, pr;
      logic [3:0]  c0, c1, ectr;
      logic [31:0] a0, a1, b0, b1, ea, eb;
      @(negedge clk);
      check_eq("p0_valid", 128'(bus.p0_valid), 128'(m_pv[0]));
      check_eq("p0_resp",  128'({bus.p0_flags, bus.p0_data}), 128'(m_res[0]));
      check_eq("p1_valid", 128'(bus.p1_valid), 128'(m_pv[1]));
      check_eq("p1_resp",  128'({bus.p1_flags, bus.p1_data}), 128'(m_res[1]));
      c0 = bus.r0_ctr; a0 = bus.r0_a; b0 = bus.r0_b;
      c1 = bus.r1_ctr; a1 = bus.r1_a; b1 = bus.r1_b;
      pr = {bus.p1_ready, bus.p0_ready};
      el[0] = bus.r0_valid && (!m_pv[0] || pr[0]);
      el[1] = bus.r1_valid && (!m_pv[1] || pr[1]);
      if (el == 2'b11) gr = m_lg ? 2'b01 : 2'b10;
      else             gr = el;
      if (rst) gr = 2'b00;
      check_eq("r0_ready", 128'(bus.r0_ready), 128'(gr[0]));
      check_eq("r1_ready", 128'(bus.r1_ready), 128'(gr[1]));
      if (!rst) begin
         ectr = gr[0] ? c0 : (gr[1] ? c1 : 4'd0);
         ea   = gr[0] ? a0 : (gr[1] ? a1 : 32'd0);
         eb   = gr[0] ? b0 : (gr[1] ? b1 : 32'd0);
         check_eq("alu_drive", 128'({alu_ctr, alu_a, alu_b}), 128'({ectr, ea, eb}));
      end
      obs_gr = {bus.r1_ready, bus.r0_ready};
      if (gr[0]) $display("txn t=%0t req=0 ctr=%b a=%h b=%h", $time, c0, a0, b0);
      if (gr[1]) $display("txn t=%0t req=1 ctr=%b a=%h b=%h", $time, c1, a1, b1);
      @(posedge clk);
      if (rst) begin
         m_pv = 2'b00; m_res[0] = '0; m_res[1] = '0; m_lg = 1'b1;
      end else begin
         if (gr[0]) begin
            m_pv[0] = 1'b1; m_res[0] = alu_fn(c0, a0, b0); m_lg = 1'b0;
         end else if (m_pv[0] && pr[0]) m_pv[0] = 1'b0;
         if (gr[1]) begin
            m_pv[1] = 1'b1; m_res[1] = alu_fn(c1, a1, b1); m_lg = 1'b1;
         end else if (m_pv[1] && pr[1]) m_pv[1] = 1'b0;
      end
      m_gr = gr;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0]  seq;
      int          cnt0, cnt1;
      rst = 1'b1;
      set_r0(1'b1, 4'b0000, 32'd7, 32'd1);
      set_r1(1'b0, 4'b0000, 32'd0, 32'd0);
      bus.p0_ready = 1'b0;
      bus.p1_ready = 1'b0;
      m_pv = 2'b00; m_res[0] = '0; m_res[1] = '0; m_lg = 1'b1; m_gr = 2'b00; obs_gr = 2'b00;
      #1;
      check_eq("rst_r0_ready", 128'(bus.r0_ready), 128'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.r0_valid = 1'b0;
      check_eq("rst_p0_valid", 128'(bus.p0_valid), 128'd0);
      check_eq("rst_p1_valid", 128'(bus.p1_valid), 128'd0);
      check_eq("rst_p0_data",  128'(bus.p0_data),  128'd0);
      check_eq("rst_p1_flags", 128'(bus.p1_flags), 128'd0);

      // Single add
      set_r0(1'b1, 4'b0000, 32'd5, 32'd3);
      bus.p0_ready = 1'b1;
      #1;
      check_eq("add_r0_ready", 128'(bus.r0_ready), 128'd1);
      step();
      bus.r0_valid = 1'b0;
      check_eq("add_p0_valid", 128'(bus.p0_valid), 128'd1);
      check_eq("add_p0_data",  128'(bus.p0_data),  128'd8);
      check_eq("add_p0_flags", 128'(bus.p0_flags), 128'd0);
      step();

      // Conflict straight after reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_r0(1'b1, 4'b1000, 32'd3, 32'd5);
      set_r1(1'b1, 4'b0000, 32'd0, 32'd0);
      bus.p0_ready = 1'b1;
      bus.p1_ready = 1'b1;
      step();
      bus.r0_valid = 1'b0;
      check_eq("cf_p0_data",  128'(bus.p0_data),  128'hFFFF_FFFE);
      check_eq("cf_p1_valid", 128'(bus.p1_valid), 128'd0);
      step();
      bus.r1_valid = 1'b0;
      check_eq("cf_p1_data",  128'(bus.p1_data),     128'd0);
      check_eq("cf_p1_zero",  128'(bus.p1_flags[0]), 128'd1);

      // Alternation with both continuously eligible
      new_r0(1'b1);
      new_r1(1'b1);
      seq = '0; cnt0 = 0; cnt1 = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         seq[k] = obs_gr[1];
         cnt0 += int'(obs_gr[0]);
         cnt1 += int'(obs_gr[1]);
         if (obs_gr[0]) new_r0(1'b1);
         if (obs_gr[1]) new_r1(1'b1);
      end
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
      check_eq("alt_seq",  128'(seq),  128'b101010);
      check_eq("alt_cnt0", 128'(cnt0), 128'd3);
      check_eq("alt_cnt1", 128'(cnt1), 128'd3);
      step();

      // Backpressure on response 0
      bus.p0_ready = 1'b0;
      set_r0(1'b1, 4'b0000, 32'd100, 32'd23);
      step();
      set_r0(1'b1, 4'b0100, 32'h1234_5678, 32'h0F0F_0F0F);
      new_r1(1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("bp_r0_ready", 128'(bus.r0_ready), 128'd0);
         check_eq("bp_r1_ready", 128'(bus.r1_ready), 128'd1);
         check_eq("bp_p0_data",  128'(bus.p0_data),  128'd123);
         step();
         new_r1(1'b1);
      end
      bus.p0_ready = 1'b1;
      #1;
      check_eq("bp_release_r0", 128'(bus.r0_ready), 128'd1);
      step();
      bus.r0_valid = 1'b0;
      step();
      bus.r1_valid = 1'b0;
      step();

      // Reset while a response is pending
      set_r1(1'b1, 4'b0000, 32'd9, 32'd9);
      bus.p1_ready = 1'b0;
      step();
      bus.r1_valid = 1'b0;
      set_r0(1'b1, 4'b0110, 32'hA5A5_0000, 32'h0000_5A5A);
      rst = 1'b1;
      #1;
      check_eq("mr_r0_ready", 128'(bus.r0_ready), 128'd0);
      step();
      rst = 1'b0;
      check_eq("mr_p0_valid", 128'(bus.p0_valid), 128'd0);
      check_eq("mr_p1_valid", 128'(bus.p1_valid), 128'd0);
      set_r1(1'b1, 4'b0111, 32'hFFFF_0000, 32'h00FF_FF00);
      bus.p0_ready = 1'b1;
      bus.p1_ready = 1'b1;
      #1;
      check_eq("mr_r0_wins", 128'(bus.r0_ready), 128'd1);
      check_eq("mr_r1_waits", 128'(bus.r1_ready), 128'd0);
      step();
      bus.r0_valid = 1'b0;
      step();
      bus.r1_valid = 1'b0;
      step();

      // SLT through requester 1
      set_r1(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
      step();
      bus.r1_valid = 1'b0;
      check_eq("slt_p1_data", 128'(bus.p1_data),     128'd1);
      check_eq("slt_p1_less", 128'(bus.p1_flags[2]), 128'd1);
      step();

      // Randomized traffic against the model
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst = ($urandom_range(0, 99) == 0);
         bus.p0_ready = ($urandom_range(0, 3) != 0);
         bus.p1_ready = ($urandom_range(0, 3) != 0);
         if (!bus.r0_valid || m_gr[0]) new_r0($urandom_range(0, 2) != 0);
         if (!bus.r1_valid || m_gr[1]) new_r1($urandom_range(0, 2) != 0);
         step();
      end
      rst = 1'b0;
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
      bus.p0_ready = 1'b1;
      bus.p1_ready = 1'b1;
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational ALU instance between two requesters.
- Requester 0 is the EXU integer path; requester 1 is the address-generation / LSU path.
- Each request carries an ALU control code and two operands. The block drives the shared ALU, captures its result and flags into a per-requester response register, and returns them over a valid/ready channel.
- It sits in the execute stage, between the requesters and the ALU.

Parameters:
- BITS, 32, operand/result width. Must match the shared ALU's BITS.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- r0_valid  in  1  requester 0 request valid
- r0_ready  out  1  requester 0 request accepted this cycle
- r0_ctr  in  4  requester 0 ALU control code
- r0_a  in  BITS  requester 0 operand A
- r0_b  in  BITS  requester 0 operand B
- r1_valid, r1_ready, r1_ctr, r1_a, r1_b  same as r0_*, for requester 1
- alu_ctr  out  4  to shared ALU control
- alu_a  out  BITS  to shared ALU operand A
- alu_b  out  BITS  to shared ALU operand B
- alu_out  in  BITS  from shared ALU result
- alu_zero, alu_carry, alu_less, alu_overflow  in  1 each  from shared ALU flags
- p0_valid  out  1  response 0 valid
- p0_ready  in  1  response 0 consumer ready
- p0_data  out  BITS  response 0 result
- p0_flags  out  4  response 0 flags, packed {overflow, less, carry, zero}
- p1_valid, p1_ready, p1_data, p1_flags  same as p0_*, for requester 1

Behaviour:
- **State:**
  - last_grant: 1 bit.
  - p0 and p1 response registers: valid bit, data, flags.
- **Reset** (rst high at a clock edge):
  - last_grant=1, so requester 0 wins the first conflict.
  - p0_valid=p1_valid=0; p*_data=0; p*_flags=0.
  - rst overrides all same-cycle handshakes. A request presented during reset is not accepted (r*_ready=0 while rst=1), and a pending response is dropped.
- **Eligibility** (combinational):
  - elig_i = ri_valid && (!pi_valid || pi_ready).
  - A response slot freed this cycle may be refilled this cycle.
- **Grant:**
  - Only one eligible: it is granted.
  - Both eligible: grant the requester != last_grant.
  - None eligible: no grant.
  - ri_ready = grant_i && !rst. This depends combinationally on ri_valid and pi_ready. Requesters must not make ri_valid depend on ri_ready.
- **ALU drive** (combinational):
  - Granted requester's ctr/a/b is routed to alu_ctr/alu_a/alu_b.
  - No grant: alu_ctr=0, alu_a=0, alu_b=0.
- **Capture on grant_i at the clock edge:**
  - pi_valid<=1, pi_data<=alu_out.
  - pi_flags<={alu_overflow, alu_less, alu_carry, alu_zero}.
  - last_grant<=i.
- **Release:** pi_valid && pi_ready with no new grant_i → pi_valid<=0. Data and flags hold their last value.
- **Hold:** pi_valid && !pi_ready → data and flags are held stable; requester i is ineligible.
- **last_grant** changes only on a grant.
- **Latency:** request accepted at edge N → pi_valid=1 from edge N (visible in cycle N+1).
- **Throughput:**
  - Per requester: 1 result/cycle when pi_ready is held high.
  - Aggregate: 1 result/cycle.
- **Fairness:** with both requesters continuously eligible, grants strictly alternate 0,1,0,1.
- **Stability:** requesters must hold ri_* stable while ri_valid && !ri_ready. A request is never dropped or duplicated.

Test Plan:
- Single add, shared ALU instance bound in the bench:
  - Stimulus: reset, then r0_valid=1, ctr=4'b0000, a=5, b=3, p0_ready=1.
  - Required: r0_ready=1 same cycle; next cycle p0_valid=1, p0_data=8, p0_flags=4'b0000.
- Conflict after reset:
  - Stimulus: r0 (sub, ctr=4'b1000, a=3, b=5) and r1 (ctr=4'b0000, a=0, b=0) asserted together.
  - Required, cycle 1: r0 granted → p0_data=32'hFFFFFFFE.
  - Required, cycle 2: r1 granted → p1_data=0, p1_flags[0]=1.
- Alternation:
  - Stimulus: both valid continuously for 6 cycles, p*_ready=1.
  - Required: grant sequence 0,1,0,1,0,1; each port produces exactly 3 responses.
- Backpressure:
  - Stimulus: p0_ready=0 with p0_valid=1; r0_valid=1 and r1_valid=1.
  - Required while p0_ready=0: r0_ready=0; r1 granted every cycle; p0_data unchanged.
  - Required when p0_ready rises: r0 granted that same cycle.
- Mid-operation reset:
  - Stimulus: p1_valid=1 pending, r0_valid=1; rst=1 for one cycle.
  - Required: r0_ready=0 during reset; after reset p0_valid=p1_valid=0.
  - Required on the next conflict: requester 0 wins.
- SLT through the arbiter:
  - Stimulus: r1, ctr=4'b0010, a=32'hFFFFFFFF, b=1.
  - Required: p1_data=1, p1_flags[2]=1.
